// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder.
//   state_t    : 2-bit binary state encoding (code 2'b11 is unused/illegal)
//   RPTCNT_MAX : value at which the repeat counter saturates
package button_event_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_HELD     = 2'b01,
      ST_LONGHELD = 2'b10
   } state_t;

   localparam logic [3:0] RPTCNT_MAX = 4'd15;

endpackage

// File: rtl/button_edge_detect.sv
// Rise/fall strobe generator for a debounced, already-synchronous level.
//   clk  : clock, rising edge
//   rstn : synchronous active-low reset
//   btn  : input level
//   rise : combinational strobe, btn=1 while previous sample was 0
//   fall : combinational strobe, btn=0 while previous sample was 1
// The previous-level register resets to 1 so a level held high through
// reset is not mistaken for a fresh rising edge.
module button_edge_detect (
   input  logic clk,
   input  logic rstn,
   input  logic btn,
   output logic rise,
   output logic fall
);

   logic btn_prev;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         btn_prev <= 1'b1;
      end else begin
         btn_prev <= btn;
      end
   end

   assign rise = btn & ~btn_prev;
   assign fall = ~btn & btn_prev;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle events.
//   IPTCLK     : clock, rising edge
//   IPTRSTN    : synchronous active-low reset
//   IPTBTN     : debounced button level, 1 = pressed
//   OUTPRESS   : pulse after a press edge
//   OUTRELEASE : pulse after any release edge
//   OUTSHORT   : pulse after a release that came before the long-press point
//   OUTLONG    : pulse when the hold reaches LONG_CYCLES edges
//   OUTREPEAT  : pulse every REPEAT_CYCLES edges while in long-hold
//   OUTHOLD    : level, high while in long-hold
//   OUTRPTCNT  : repeats issued in the current hold, saturating at 15
// All outputs are registered (one cycle after the detecting edge).
module button_event_decoder
   import button_event_decoder_pkg::*;
#(
   parameter int LONG_CYCLES   = 16,
   parameter int REPEAT_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic       IPTCLK,
   input  logic       IPTRSTN,
   input  logic       IPTBTN,
   output logic       OUTPRESS,
   output logic       OUTRELEASE,
   output logic       OUTSHORT,
   output logic       OUTLONG,
   output logic       OUTREPEAT,
   output logic       OUTHOLD,
   output logic [3:0] OUTRPTCNT
);

   localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] RPT_TC  = CNT_W'(REPEAT_CYCLES - 1);

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == RPTCNT_MAX) ? v : v + 4'd1;
   endfunction

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             rise, fall;
   logic             press_n, release_n, short_n, long_n, repeat_n, hold_n;
   logic [3:0]       rptcnt_n;

   button_edge_detect u_edge (
      .clk  (IPTCLK),
      .rstn (IPTRSTN),
      .btn  (IPTBTN),
      .rise (rise),
      .fall (fall)
   );

   // State, counter and output registers
   always_ff @(posedge IPTCLK) begin
      if (!IPTRSTN) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         OUTPRESS   <= 1'b0;
         OUTRELEASE <= 1'b0;
         OUTSHORT   <= 1'b0;
         OUTLONG    <= 1'b0;
         OUTREPEAT  <= 1'b0;
         OUTHOLD    <= 1'b0;
         OUTRPTCNT  <= 4'd0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         OUTPRESS   <= press_n;
         OUTRELEASE <= release_n;
         OUTSHORT   <= short_n;
         OUTLONG    <= long_n;
         OUTREPEAT  <= repeat_n;
         OUTHOLD    <= hold_n;
         OUTRPTCNT  <= rptcnt_n;
      end
   end

   // Next state and hold counter. Both hold states are only entered or kept
   // with the button high, so the previous level is 1 there and 'fall' is
   // the same as the button reading 0. Release wins over terminal count.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         ST_IDLE: begin
            if (rise) begin
               state_n = ST_HELD;
               cnt_n   = '0;
            end
         end
         ST_HELD: begin
            if (fall) begin
               state_n = ST_IDLE;
            end else if (cnt == LONG_TC) begin
               state_n = ST_LONGHELD;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ST_LONGHELD: begin
            if (fall) begin
               state_n = ST_IDLE;
            end else if (cnt == RPT_TC) begin
               cnt_n = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // Event decode, registered by the block above
   always_comb begin
      press_n   = (state == ST_IDLE) && rise;
      release_n = ((state == ST_HELD) || (state == ST_LONGHELD)) && fall;
      short_n   = (state == ST_HELD) && fall;
      long_n    = (state == ST_HELD) && !fall && (cnt == LONG_TC);
      repeat_n  = (state == ST_LONGHELD) && !fall && (cnt == RPT_TC);
      hold_n    = (state_n == ST_LONGHELD);
      rptcnt_n  = OUTRPTCNT;
      if (press_n) begin
         rptcnt_n = 4'd0;
      end else if (repeat_n) begin
         rptcnt_n = sat_inc(OUTRPTCNT);
      end
   end

endmodule

// File: tb/tb_button_event_decoder.sv
module tb_button_event_decoder;

   logic       clk  = 1'b0;
   logic       rstn = 1'b0;
   logic       btn  = 1'b0;

   logic       press_a, release_a, short_a, long_a, repeat_a, hold_a;
   logic [3:0] rptcnt_a;
   logic       press_b, release_b, short_b, long_b, repeat_b, hold_b;
   logic [3:0] rptcnt_b;
   logic [9:0] obs_a, obs_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   button_event_decoder #(.LONG_CYCLES(16), .REPEAT_CYCLES(4), .CNT_W(8)) dut_a (
      .IPTCLK(clk), .IPTRSTN(rstn), .IPTBTN(btn),
      .OUTPRESS(press_a), .OUTRELEASE(release_a), .OUTSHORT(short_a),
      .OUTLONG(long_a), .OUTREPEAT(repeat_a), .OUTHOLD(hold_a),
      .OUTRPTCNT(rptcnt_a)
   );

   button_event_decoder #(.LONG_CYCLES(16), .REPEAT_CYCLES(1), .CNT_W(8)) dut_b (
      .IPTCLK(clk), .IPTRSTN(rstn), .IPTBTN(btn),
      .OUTPRESS(press_b), .OUTRELEASE(release_b), .OUTSHORT(short_b),
      .OUTLONG(long_b), .OUTREPEAT(repeat_b), .OUTHOLD(hold_b),
      .OUTRPTCNT(rptcnt_b)
   );

   assign obs_a = {press_a, release_a, short_a, long_a, repeat_a, hold_a, rptcnt_a};
   assign obs_b = {press_b, release_b, short_b, long_b, repeat_b, hold_b, rptcnt_b};

   // Reference model: tracks how many edges the button has been held since
   // the press edge and derives every event from that count arithmetically.
   int         m_long[2] = '{16, 16};
   int         m_rep[2]  = '{4, 1};
   bit         m_active[2];
   int         m_h[2];
   bit         m_prev[2];
   int         m_rpt[2];
   logic [9:0] m_exp[2];

   task automatic model_step(input int i, input logic b, input logic r);
      bit pr, rl, sh, lg, rp, hd;
      pr = 0; rl = 0; sh = 0; lg = 0; rp = 0;
      if (!r) begin
         m_active[i] = 0;
         m_h[i]      = 0;
         m_prev[i]   = 1;
         m_rpt[i]    = 0;
      end else begin
         if (!m_active[i]) begin
            if (b && !m_prev[i]) begin
               pr = 1; m_active[i] = 1; m_h[i] = 0; m_rpt[i] = 0;
            end
         end else if (!b) begin
            rl = 1;
            sh = (m_h[i] < m_long[i]);
            m_active[i] = 0;
         end else begin
            m_h[i]++;
            if (m_h[i] == m_long[i]) begin
               lg = 1;
            end else if (m_h[i] > m_long[i] && ((m_h[i] - m_long[i]) % m_rep[i]) == 0) begin
               rp = 1;
               if (m_rpt[i] < 15) m_rpt[i]++;
            end
         end
         m_prev[i] = b;
      end
      hd = m_active[i] && (m_h[i] >= m_long[i]);
      m_exp[i] = {pr, rl, sh, lg, rp, hd, 4'(m_rpt[i])};
   endtask

   // Drive one edge (inputs change on the falling edge), update the model,
   // and return at the next falling edge where outputs are sampled.
   task automatic cyc(input logic b, input logic r);
      btn  = b;
      rstn = r;
      @(posedge clk);
      model_step(0, b, r);
      model_step(1, b, r);
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int n = 0; n < 3; n++) begin
         cyc(1'($urandom_range(0, 1)), 1'b0);
         checks++;
         if (obs_a !== 10'd0) begin
            errors++; $display("FAIL reset_a got=%b want=%b", obs_a, 10'd0);
         end
         checks++;
         if (obs_b !== m_exp[1]) begin
            errors++; $display("FAIL reset_b got=%b want=%b", obs_b, m_exp[1]);
         end
      end
   endtask

   task automatic test_press_pulse();
      logic sb[5] = '{0, 0, 1, 1, 1};
      for (int n = 0; n < 5; n++) begin
         cyc(sb[n], 1'b1);
         checks++;
         if (obs_a !== m_exp[0]) begin
            errors++; $display("FAIL press_a n=%0d got=%b want=%b", n, obs_a, m_exp[0]);
         end
         if (n == 2) begin
            checks++;
            if (press_a !== 1'b1) begin
               errors++; $display("FAIL press_edge3 got=%b want=1", press_a);
            end
         end
      end
   endtask

   task automatic test_short_click();
      // press already sampled; hold to 5 edges total then drop
      for (int n = 0; n < 3; n++) cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b1);
      checks++;
      if ({release_a, short_a, long_a, hold_a, repeat_a} !== 5'b11000) begin
         errors++;
         $display("FAIL short_click got=%b want=11000", {release_a, short_a, long_a, hold_a, repeat_a});
      end
      checks++;
      if (obs_b !== m_exp[1]) begin
         errors++; $display("FAIL short_click_b got=%b want=%b", obs_b, m_exp[1]);
      end
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
   endtask

   task automatic test_long_repeat();
      for (int e = 0; e <= 31; e++) begin
         cyc(e == 31 ? 1'b0 : 1'b1, 1'b1);
         checks++;
         if (obs_a !== m_exp[0]) begin
            errors++; $display("FAIL long_a e=%0d got=%b want=%b", e, obs_a, m_exp[0]);
         end
         checks++;
         if (obs_b !== m_exp[1]) begin
            errors++; $display("FAIL long_b e=%0d got=%b want=%b", e, obs_b, m_exp[1]);
         end
         if (e == 30) begin
            checks++;
            if (rptcnt_a !== 4'd3 || hold_a !== 1'b1) begin
               errors++; $display("FAIL long_rptcnt got=%0d hold=%b want=3 hold=1", rptcnt_a, hold_a);
            end
         end
      end
      checks++;
      if ({release_a, short_a, hold_a} !== 3'b100) begin
         errors++; $display("FAIL long_release got=%b want=100", {release_a, short_a, hold_a});
      end
   endtask

   task automatic test_release_at_long();
      logic saw_long;
      saw_long = 1'b0;
      cyc(1'b0, 1'b1);
      for (int e = 0; e <= 16; e++) begin
         cyc(e == 16 ? 1'b0 : 1'b1, 1'b1);
         saw_long = saw_long | long_a;
         checks++;
         if (obs_a !== m_exp[0]) begin
            errors++; $display("FAIL rel_long e=%0d got=%b want=%b", e, obs_a, m_exp[0]);
         end
      end
      checks++;
      if (saw_long !== 1'b0 || release_a !== 1'b1 || short_a !== 1'b1) begin
         errors++;
         $display("FAIL rel_long_prio got long=%b rel=%b short=%b want 0 1 1", saw_long, release_a, short_a);
      end
   endtask

   task automatic test_reset_held();
      int presses;
      presses = 0;
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      for (int n = 0; n < 4; n++) begin
         cyc(1'b1, 1'b1);
         presses += int'(press_a);
      end
      checks++;
      if (presses != 0) begin
         errors++; $display("FAIL held_through_reset got presses=%0d want=0", presses);
      end
      cyc(1'b0, 1'b1);
      for (int n = 0; n < 20; n++) begin
         cyc(1'b1, 1'b1);
         presses += int'(press_a);
         checks++;
         if (obs_a !== m_exp[0]) begin
            errors++; $display("FAIL reheld_a n=%0d got=%b want=%b", n, obs_a, m_exp[0]);
         end
      end
      checks++;
      if (presses != 1 || hold_a !== 1'b1) begin
         errors++; $display("FAIL repress got presses=%0d hold=%b want 1 1", presses, hold_a);
      end
      cyc(1'b1, 1'b0);
      checks++;
      if (hold_a !== 1'b0 || release_a !== 1'b0 || obs_a !== m_exp[0]) begin
         errors++; $display("FAIL reset_in_long got=%b want=%b", obs_a, m_exp[0]);
      end
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b1);
      checks++;
      if (obs_a !== m_exp[0] || obs_b !== m_exp[1]) begin
         errors++; $display("FAIL after_reset_long got=%b/%b want=%b/%b", obs_a, obs_b, m_exp[0], m_exp[1]);
      end
   endtask

   task automatic test_saturate();
      for (int e = 0; e <= 56; e++) begin
         cyc(1'b1, 1'b1);
         checks++;
         if (obs_b !== m_exp[1]) begin
            errors++; $display("FAIL sat_b e=%0d got=%b want=%b", e, obs_b, m_exp[1]);
         end
      end
      checks++;
      if (rptcnt_b !== 4'd15 || repeat_b !== 1'b1) begin
         errors++; $display("FAIL sat_value got=%0d rep=%b want=15 rep=1", rptcnt_b, repeat_b);
      end
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      checks++;
      if (rptcnt_b !== 4'd15) begin
         errors++; $display("FAIL sat_idle_hold got=%0d want=15", rptcnt_b);
      end
      cyc(1'b1, 1'b1);
      checks++;
      if (rptcnt_b !== 4'd0 || press_b !== 1'b1) begin
         errors++; $display("FAIL sat_clear got=%0d press=%b want=0 press=1", rptcnt_b, press_b);
      end
      cyc(1'b0, 1'b1);
   endtask

   task automatic test_random();
      int   run;
      logic b, r;
      run = 0;
      b   = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         if (run == 0) begin
            b   = ~b;
            run = int'($urandom_range(1, 40));
         end
         run--;
         r = ($urandom_range(0, 199) != 0);
         cyc(b, r);
         checks++;
         if (obs_a !== m_exp[0]) begin
            errors++; $display("FAIL random_a n=%0d got=%b want=%b", n, obs_a, m_exp[0]);
         end
         checks++;
         if (obs_b !== m_exp[1]) begin
            errors++; $display("FAIL random_b n=%0d got=%b want=%b", n, obs_b, m_exp[1]);
         end
         checks++;
         if (press_a && release_a) begin
            errors++; $display("FAIL press_release_overlap got=11 want=not both");
         end
      end
   endtask

   initial begin
      test_reset();
      test_press_pulse();
      test_short_click();
      test_long_repeat();
      test_release_at_long();
      test_reset_held();
      test_saturate();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumer-side counterpart to the 4-bit button debouncer. It takes the clean debounced button level and turns it into discrete one-cycle events: press, release, short click, long press and auto-repeat.
- Placed directly after each debouncer instance, in the same clock domain. Feeds menu/counter logic that needs events rather than levels.

Parameters:
- LONG_CYCLES, default 16: edges button must stay held after the press edge before OUTLONG fires. Legal range is 2 or more.
- REPEAT_CYCLES, default 4: edges between consecutive OUTREPEAT pulses once in long-hold. Legal range is 1 or more.
- CNT_W, default 8: hold-counter width. The implementation must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).

Ports:
- IPTCLK  input  1  system clock; all logic on its rising edge.
- IPTRSTN  input  1  synchronous active-low reset.
- IPTBTN  input  1  debounced button level, synchronous to IPTCLK, 1 = pressed.
- OUTPRESS  output  1  one-cycle pulse on a press edge.
- OUTRELEASE  output  1  one-cycle pulse on any release edge.
- OUTSHORT  output  1  one-cycle pulse on release before long-press was reached.
- OUTLONG  output  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- OUTREPEAT  output  1  one-cycle pulse every REPEAT_CYCLES while in long-hold.
- OUTHOLD  output  1  level, high while in state LONGHELD.
- OUTRPTCNT  output  4  repeats issued in the current hold; saturates at 15.

Behaviour:
- Clock and reset: one clock, IPTCLK. Reset IPTRSTN is synchronous and active-low: sampled low at a rising edge, it forces reset on that edge.
- Reset values:
  - All outputs 0, OUTRPTCNT = 0.
  - State = IDLE, hold counter = 0.
  - Previous-level register btn_prev = 1, so a button held through reset produces no OUTPRESS until it is released and pressed again.
- Registers: all outputs are registered. Event pulses are high for exactly the one cycle following the edge that detected the event (latency 1 cycle). Pulses default to 0 every edge unless set.
- State IDLE:
  - On IPTBTN=1 with btn_prev=0: set OUTPRESS, clear cnt and OUTRPTCNT, go to HELD.
  - Otherwise stay in IDLE.
- State HELD:
  - If IPTBTN=0: set OUTRELEASE and OUTSHORT, go to IDLE.
  - Else if cnt == LONG_CYCLES-1: set OUTLONG, clear cnt, go to LONGHELD.
  - Else: cnt++.
  - With the press sampled at edge E0, OUTLONG follows edge E0+LONG_CYCLES.
- State LONGHELD (OUTHOLD=1):
  - If IPTBTN=0: set OUTRELEASE only, go to IDLE, OUTHOLD returns to 0.
  - Else if cnt == REPEAT_CYCLES-1: set OUTREPEAT, clear cnt, OUTRPTCNT++ saturating at 15.
  - Else: cnt++.
  - Repeat pulses follow edges E0+LONG_CYCLES+k*REPEAT_CYCLES, k = 1, 2, …
- btn_prev <= IPTBTN every non-reset edge.
- Simultaneous events: release has priority over the OUTLONG/OUTREPEAT terminal count in the same edge. The release pulse fires and the long/repeat pulse is suppressed.
- OUTPRESS and OUTRELEASE never assert in the same cycle.
- OUTRPTCNT holds its value in IDLE after release and is cleared only on the next press.
- Reset mid-operation: on the resetting edge, all pulses and OUTHOLD go to 0 and the state returns to IDLE. No OUTRELEASE is generated.
- Encoding: the state encoding is 2-bit binary; the 4th code is illegal and recovers to IDLE on the next edge.

Decomposition:
- Shared package holds the state encoding constants (IDLE, HELD, LONGHELD) and the OUTRPTCNT saturation value 15.
- One natural sub-module, button_edge_detect: holds btn_prev (reset value 1) and gives rise/fall strobes. It is reusable for other debounced inputs.

Test Plan (LONG_CYCLES=16, REPEAT_CYCLES=4):
- Reset released with IPTBTN=0; raise IPTBTN sampled at edge 3 -> OUTPRESS=1 for the cycle after edge 3 only; all other outputs 0.
- Hold 5 edges then drop IPTBTN -> one OUTRELEASE and one OUTSHORT pulse, same cycle; OUTLONG, OUTHOLD and OUTREPEAT stay 0.
- Press at E0, hold to E30 -> OUTLONG after E16; OUTHOLD high from E16; OUTREPEAT after E20, E24, E28; OUTRPTCNT=3; release at E31 -> OUTRELEASE=1, OUTSHORT=0, OUTHOLD=0.
- Press at E0, release sampled at E16 -> OUTRELEASE and OUTSHORT fire; OUTLONG never asserts.
- Reset with IPTBTN=1 held through and after reset -> no OUTPRESS; release then press -> exactly one OUTPRESS. Reset asserted in LONGHELD -> OUTHOLD=0 next cycle, no OUTRELEASE.
- REPEAT_CYCLES=1, hold for 40 edges past long -> OUTREPEAT every cycle, OUTRPTCNT saturates at 15 and stays there until the next press clears it.
